arm7tdmi_mini_top: RTL and testbench

Minimal multicycle ARM-state core top level. It fetches 32-bit ARM instructions from a single-port word memory and executes a small subset: MOV/MVN immediate, B/BL, and MRC/MCR to an internal CP15. Other coprocessor accesses raise the undefined-instruction exception. It is the processor block under the system memory model and is used to verify coprocessor decode and exception entry.

---
 rtl/arm7tdmi_mini_top_if.sv | 21 ++
 rtl/arm7tdmi_mini_top.sv | 239 +++++++++++++++++++++++
 tb/tb_arm7tdmi_mini_top.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm7tdmi_mini_top_if.sv
// Word-wide instruction memory port of the mini ARM core.
// The core owns address/strobes; memory returns read data and a ready stall.
interface arm7tdmi_mini_top_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  mem_be;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re, mem_be,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re, mem_be,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/arm7tdmi_mini_top.sv
// Minimal multicycle ARM-state core: MOV/MVN imm, B/BL, MRC/MCR to CP15,
// undefined-instruction entry for every other coprocessor access.
module arm7tdmi_mini_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        und_bank,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        exc_we,
    input  logic [31:0] exc_lr,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] regs_user [0:14];
    logic [31:0] r13_und;
    logic [31:0] r14_und;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < 15; i++) regs_user[i] <= '0;
            r13_und <= '0;
            r14_und <= '0;
        end else begin
            if (we && waddr != 4'd15) begin
                if (und_bank && waddr == 4'd13)      r13_und <= wdata;
                else if (und_bank && waddr == 4'd14) r14_und <= wdata;
                else                                 regs_user[waddr] <= wdata;
            end
            if (exc_we) r14_und <= exc_lr;
        end
    end

    // R15 is supplied by the core (instruction address + 8), so it reads 0 here.
    always_comb begin
        rdata = '0;
        if (raddr == 4'd15)                      rdata = '0;
        else if (und_bank && raddr == 4'd13)     rdata = r13_und;
        else if (und_bank && raddr == 4'd14)     rdata = r14_und;
        else                                     rdata = regs_user[raddr];
    end
endmodule

module arm7tdmi_mini_top (
    input  logic                clk,
    input  logic                rst_n,
    arm7tdmi_mini_top_if.master mem,
    input  logic                debug_en,
    output logic [31:0]         debug_pc,
    output logic [31:0]         debug_instr,
    input  logic                irq,
    input  logic                fiq,
    input  logic                halt,
    output logic                running
);
    localparam logic [31:0] CP15_ID = 32'h4100_7700;
    localparam logic [31:0] C1_MASK = 32'h0000_3384;

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXECUTE, S_IDLE} state_t;
    typedef enum logic [1:0] {INSTR_OTHER, INSTR_DATA, INSTR_BRANCH, INSTR_COPROCESSOR} instr_type_t;
    typedef enum logic [1:0] {CP_OP_NONE, CP_OP_MRC, CP_OP_MCR, CP_OP_UNSUPPORTED} cp_op_t;

    state_t      current_state, next_state;
    logic [31:0] pc, instr_q, cpsr, spsr_und, cp15_c1;
    logic [31:0] pc_next, cpsr_next, c1_next;
    instr_type_t decode_instr_type;
    cp_op_t      decode_cp_op;
    logic [3:0]  decode_cp_num, decode_cp_rd, decode_cp_rn;
    logic [2:0]  decode_cp_opcode1, decode_cp_opcode2;
    logic        cp_present, cp_ready, cp_access_ok, cp_exception;
    logic        undefined_exception, fetch_instruction;
    logic        cond_ok, exec_en, is_mov, und_bank;
    logic [4:0]  rot_amt;
    logic [31:0] imm_rot, mov_result, cp_rdata, mcr_data, rf_rdata, rf_wdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic        unused_ok;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: cond_pass = z;              4'h1: cond_pass = !z;
            4'h2: cond_pass = c;              4'h3: cond_pass = !c;
            4'h4: cond_pass = n;              4'h5: cond_pass = !n;
            4'h6: cond_pass = v;              4'h7: cond_pass = !v;
            4'h8: cond_pass = c && !z;        4'h9: cond_pass = !c || z;
            4'hA: cond_pass = n == v;         4'hB: cond_pass = n != v;
            4'hC: cond_pass = !z && (n == v); 4'hD: cond_pass = z || (n != v);
            4'hE: cond_pass = 1'b1;           default: cond_pass = 1'b0;
        endcase
    endfunction

    assign decode_cp_num     = instr_q[11:8];
    assign decode_cp_rd      = instr_q[15:12];
    assign decode_cp_rn      = instr_q[19:16];
    assign decode_cp_opcode1 = instr_q[23:21];
    assign decode_cp_opcode2 = instr_q[7:5];
    assign cp_present        = decode_cp_num == 4'hF;
    assign cp_ready          = 1'b1;
    assign cp_access_ok      = cp_present && decode_cp_opcode1 == 3'd0 &&
                               decode_cp_opcode2 == 3'd0 && instr_q[3:0] == 4'd0;

    always_comb begin
        decode_instr_type = INSTR_OTHER;
        decode_cp_op      = CP_OP_NONE;
        if (instr_q[27:26] == 2'b11) begin
            decode_instr_type = INSTR_COPROCESSOR;
            // 1111 is SWI space, not a coprocessor access: left as a NOP.
            if (instr_q[25:24] == 2'b10 && instr_q[4])
                decode_cp_op = instr_q[20] ? CP_OP_MRC : CP_OP_MCR;
            else if (instr_q[25:24] != 2'b11)
                decode_cp_op = CP_OP_UNSUPPORTED;
        end else if (instr_q[27:25] == 3'b101) begin
            decode_instr_type = INSTR_BRANCH;
        end else if (instr_q[27:26] == 2'b00) begin
            decode_instr_type = INSTR_DATA;
        end
    end

    assign cp_exception = decode_cp_op == CP_OP_UNSUPPORTED ||
                          ((decode_cp_op == CP_OP_MRC || decode_cp_op == CP_OP_MCR) && !cp_access_ok);
    assign cond_ok             = cond_pass(instr_q[31:28], cpsr[31:28]);
    assign exec_en             = current_state == S_EXECUTE && cond_ok;
    assign undefined_exception = exec_en && cp_exception;
    assign und_bank            = cpsr[4:0] == 5'h1B;
    assign is_mov = decode_instr_type == INSTR_DATA && instr_q[25] &&
                    (instr_q[24:21] == 4'hD || instr_q[24:21] == 4'hF) && instr_q[19:16] == 4'd0;

    assign rot_amt    = {instr_q[11:8], 1'b0};
    assign imm_rot    = ({24'd0, instr_q[7:0]} >> rot_amt) |
                        ({24'd0, instr_q[7:0]} << (6'd32 - {1'b0, rot_amt}));
    assign mov_result = instr_q[22] ? ~imm_rot : imm_rot;
    assign mcr_data   = (decode_cp_rd == 4'd15) ? pc + 32'd8 : rf_rdata;

    always_comb begin
        case (decode_cp_rn)
            4'd0:    cp_rdata = CP15_ID;
            4'd1:    cp_rdata = cp15_c1;
            default: cp_rdata = '0;
        endcase
    end

    always_comb begin
        pc_next   = pc + 32'd4;
        cpsr_next = cpsr;
        c1_next   = cp15_c1;
        rf_we     = 1'b0;
        rf_waddr  = decode_cp_rd;
        rf_wdata  = mov_result;
        if (undefined_exception) begin
            pc_next   = 32'h0000_0004;
            cpsr_next = {cpsr[31:8], 1'b1, cpsr[6:5], 5'h1B};
        end else if (exec_en && is_mov) begin
            if (decode_cp_rd == 4'd15) pc_next = {mov_result[31:2], 2'b00};
            else                       rf_we   = 1'b1;
            if (instr_q[20]) begin
                cpsr_next[31] = mov_result[31];
                cpsr_next[30] = mov_result == '0;
                if (rot_amt != 5'd0) cpsr_next[29] = imm_rot[31];
            end
        end else if (exec_en && decode_instr_type == INSTR_BRANCH) begin
            pc_next = pc + 32'd8 + {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
            if (instr_q[24]) begin
                rf_we    = 1'b1;
                rf_waddr = 4'd14;
                rf_wdata = pc + 32'd4;
            end
        end else if (exec_en && decode_cp_op == CP_OP_MRC) begin
            if (decode_cp_rd == 4'd15) cpsr_next[31:28] = cp_rdata[31:28];
            else begin
                rf_we    = 1'b1;
                rf_wdata = cp_rdata;
            end
        end else if (exec_en && decode_cp_op == CP_OP_MCR && decode_cp_rn == 4'd1) begin
            c1_next = mcr_data & C1_MASK;
        end
    end

    arm7tdmi_mini_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .und_bank (und_bank),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .exc_we   (undefined_exception),
        .exc_lr   (pc + 32'd4),
        .raddr    (decode_cp_rd),
        .rdata    (rf_rdata)
    );

    always_comb begin
        next_state    = current_state;
        mem.mem_re    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_wdata = '0;
        mem.mem_addr  = pc;
        case (current_state)
            S_FETCH: begin
                next_state = S_WAIT;
                mem.mem_re = !rst_n;
            end
            S_WAIT:    if (mem.mem_ready) next_state = S_EXECUTE;
            S_EXECUTE: next_state = (halt || debug_en) ? S_IDLE : S_FETCH;
            S_IDLE:    if (!halt && !debug_en) next_state = S_FETCH;
            default:   next_state = S_FETCH;
        endcase
        mem.mem_be = mem.mem_re ? 4'hF : 4'h0;
        running    = !rst_n && current_state != S_IDLE;
    end

    assign fetch_instruction = mem.mem_re;
    assign unused_ok = &{1'b0, irq, fiq, cp_ready, fetch_instruction};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            current_state <= S_FETCH;
            pc            <= '0;
            instr_q       <= '0;
            cpsr          <= 32'h0000_00D3;
            spsr_und      <= '0;
            cp15_c1       <= '0;
            debug_pc      <= '0;
            debug_instr   <= '0;
        end else begin
            current_state <= next_state;
            if (current_state == S_WAIT && mem.mem_ready) instr_q <= mem.mem_rdata;
            if (current_state == S_EXECUTE) begin
                pc          <= pc_next;
                cpsr        <= cpsr_next;
                cp15_c1     <= c1_next;
                debug_pc    <= pc;
                debug_instr <= instr_q;
                if (undefined_exception) spsr_und <= cpsr;
            end
        end
    end
endmodule

// File: tb/tb_arm7tdmi_mini_top.sv
// Bench for arm7tdmi_mini_top: directed programs plus random instruction
// streams checked against an instruction-level reference model.
module tb_arm7tdmi_mini_top;
    logic        clk = 1'b0;
    logic        rst_n, debug_en, halt, irq, fiq, running;
    logic [31:0] debug_pc, debug_instr;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    arm7tdmi_mini_top_if bus ();

    arm7tdmi_mini_top dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (bus),
        .debug_en    (debug_en),
        .debug_pc    (debug_pc),
        .debug_instr (debug_instr),
        .irq         (irq),
        .fiq         (fiq),
        .halt        (halt),
        .running     (running)
    );

    logic [31:0] mem [0:255];
    logic [31:0] rdata_q;
    always @(posedge clk) if (bus.mem_re) rdata_q <= mem[bus.mem_addr[9:2]];
    assign bus.mem_rdata = rdata_q;

    // Reference architectural state
    logic [31:0] m_reg [0:14];
    logic [31:0] m_r13u, m_r14u, m_cpsr, m_spsr, m_c1, m_pc;
    bit          m_undef;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = '0;
        m_r13u = '0; m_r14u = '0; m_spsr = '0; m_c1 = '0; m_pc = '0;
        m_cpsr = 32'h0000_00D3;
    endtask

    function automatic bit m_und_mode();
        return m_cpsr[4:0] == 5'h1B;
    endfunction

    function automatic logic [31:0] m_read(input int n);
        if (n == 15) return m_pc + 32'd8;
        if (m_und_mode() && n == 13) return m_r13u;
        if (m_und_mode() && n == 14) return m_r14u;
        return m_reg[n];
    endfunction

    task automatic m_write(input int n, input logic [31:0] v);
        if (m_und_mode() && n == 13) m_r13u = v;
        else if (m_und_mode() && n == 14) m_r14u = v;
        else m_reg[n] = v;
    endtask

    // Conditions come in complementary pairs: even code tests, odd code inverts.
    function automatic bit m_cond(input logic [3:0] c);
        bit n, z, cy, v, base;
        {n, z, cy, v} = m_cpsr[31:28];
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: base = z;            3'd1: base = cy;
            3'd2: base = n;            3'd3: base = v;
            3'd4: base = cy && !z;     3'd5: base = n == v;
            3'd6: base = !z && n == v; default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic m_exec(input logic [31:0] ins);
        logic [63:0] wide;
        logic [31:0] val, res, nxt;
        int          rot, rd, crn;
        m_undef = 0;
        nxt = m_pc + 32'd4;
        rd  = int'(ins[15:12]);
        crn = int'(ins[19:16]);
        if (m_cond(ins[31:28])) begin
            if (ins[27:25] == 3'b001 && (ins[24:21] == 4'hD || ins[24:21] == 4'hF) && ins[19:16] == 4'h0) begin
                rot  = 2 * int'(ins[11:8]);
                wide = {24'd0, ins[7:0], 24'd0, ins[7:0]} >> rot;
                val  = wide[31:0];
                res  = ins[22] ? ~val : val;
                if (rd == 15) nxt = res & 32'hFFFF_FFFC; else m_write(rd, res);
                if (ins[20]) begin
                    m_cpsr[31] = res[31];
                    m_cpsr[30] = (res == 0);
                    if (rot != 0) m_cpsr[29] = val[31];
                end
            end else if (ins[27:25] == 3'b101) begin
                if (ins[24]) m_write(14, m_pc + 32'd4);
                nxt = m_pc + 32'd8 + 32'($signed(ins[23:0])) * 32'd4;
            end else if (ins[27:24] == 4'hE && ins[4]) begin
                if (ins[11:8] == 4'hF && ins[23:21] == 0 && ins[7:5] == 0 && ins[3:0] == 0) begin
                    if (ins[20]) begin
                        val = (crn == 0) ? 32'h4100_7700 : (crn == 1) ? m_c1 : 32'd0;
                        if (rd == 15) m_cpsr[31:28] = val[31:28]; else m_write(rd, val);
                    end else if (crn == 1) begin
                        m_c1 = m_read(rd) & 32'h0000_3384;
                    end
                end else m_undef = 1;
            end else if (ins[27:26] == 2'b11 && ins[27:24] != 4'hF) begin
                m_undef = 1;
            end
        end
        if (m_undef) begin
            m_r14u = m_pc + 32'd4;
            m_spsr = m_cpsr;
            m_cpsr = {m_cpsr[31:8], 1'b1, m_cpsr[6:5], 5'h1B};
            nxt    = 32'h0000_0004;
        end
        m_pc = nxt;
    endtask

    task automatic check_state();
        for (int i = 0; i < 15; i++) chk($sformatf("R%0d", i), dut.u_regfile.regs_user[i], m_reg[i]);
        chk("r13_und", dut.u_regfile.r13_und, m_r13u);
        chk("r14_und", dut.u_regfile.r14_und, m_r14u);
        chk("cpsr", dut.cpsr, m_cpsr);
        chk("spsr_und", dut.spsr_und, m_spsr);
        chk("cp15_c1", dut.cp15_c1, m_c1);
        chk("pc", dut.pc, m_pc);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({pfx, "_mem_re"}, 32'(bus.mem_re), 32'd0);
        chk({pfx, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({pfx, "_mem_be"}, 32'(bus.mem_be), 32'd0);
        chk({pfx, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({pfx, "_debug_pc"}, debug_pc, 32'd0);
        chk({pfx, "_debug_instr"}, debug_instr, 32'd0);
        chk({pfx, "_running"}, 32'(running), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b1; halt = 1'b0; debug_en = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        m_reset();
        check_reset_outputs("rst");
        rst_n = 1'b0;
        #1;
    endtask

    // One instruction from FETCH; afterwards the core is back in FETCH.
    task automatic run_instr(input int stalls, input int idle, input bit use_dbg);
        logic [31:0] ins, old_pc;
        old_pc = m_pc;
        ins    = mem[m_pc[9:2]];
        chk("fetch_re", 32'(bus.mem_re), 32'd1);
        chk("fetch_addr", bus.mem_addr, m_pc);
        chk("fetch_be", 32'(bus.mem_be), 32'hF);
        chk("fetch_running", 32'(running), 32'd1);
        @(negedge clk);
        for (int k = 0; k < stalls; k++) begin
            bus.mem_ready = 1'b0;
            @(negedge clk);
            chk("stall_re", 32'(bus.mem_re), 32'd0);
            chk("stall_addr", bus.mem_addr, old_pc);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        m_exec(ins);
        chk("undef_pulse", 32'(dut.undefined_exception), 32'(m_undef));
        if (idle > 0) begin
            if (use_dbg) debug_en = 1'b1; else halt = 1'b1;
        end
        @(negedge clk);
        chk("debug_pc", debug_pc, old_pc);
        chk("debug_instr", debug_instr, ins);
        check_state();
        for (int k = 0; k < idle; k++) begin
            chk("idle_running", 32'(running), 32'd0);
            chk("idle_re", 32'(bus.mem_re), 32'd0);
            if (k == idle - 1) begin halt = 1'b0; debug_en = 1'b0; end
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [3:0]  cond;
        logic [23:0] off;
        w    = $urandom;
        cond = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
        case ($urandom_range(0, 9))
            0, 1, 2: w = {cond, 3'b001, ($urandom_range(0, 1) == 1) ? 4'hF : 4'hD, w[20], 4'h0,
                          4'($urandom_range(0, 14)), w[11:0]};
            3: begin
                off = 24'($urandom_range(0, 16)) - 24'd8;
                w   = {cond, 3'b101, w[24], off};
            end
            4, 5: w = {cond, 4'hE, 3'b000, w[20], 4'($urandom_range(0, 3)), w[15:12], 4'hF, 3'b000, 1'b1, 4'h0};
            6: begin
                w = {cond, 4'hE, 3'b000, w[20], 4'($urandom_range(0, 3)), w[15:12], 4'hF, 3'b000, 1'b1, 4'h0};
                case ($urandom_range(0, 3))
                    0:       w[11:8] = 4'($urandom_range(0, 14));
                    1:       w[23:21] = 3'($urandom_range(1, 7));
                    2:       w[7:5] = 3'($urandom_range(1, 7));
                    default: w[3:0] = 4'($urandom_range(1, 15));
                endcase
            end
            7: begin w[31:24] = {cond, 4'hE}; w[4] = 1'b0; end
            8: w[31:25] = {cond, 3'b110};
            default: w[31:26] = {cond, 2'b01};
        endcase
        return w;
    endfunction

    initial begin
        irq = 1'b0; fiq = 1'b0; halt = 1'b0; debug_en = 1'b0;
        bus.mem_ready = 1'b1; rst_n = 1'b1;

        // Coprocessor program from the test plan
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'hEE100F10; mem[1] = 32'hEE111F10; mem[2] = 32'hE3A02001;
        mem[3] = 32'hEE012F10; mem[4] = 32'hEE103E10; mem[5] = 32'hEE254A76;
        mem[6] = 32'hEAFFFFFE;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            run_instr((n == 2) ? 3 : 0, 0, 1'b0);
            if (n == 4) begin
                chk("und_pc", dut.pc, 32'h4);
                chk("und_r14", dut.u_regfile.r14_und, 32'h14);
                chk("und_mode", 32'(dut.cpsr[4:0]), 32'h1B);
                chk("und_r3", dut.u_regfile.regs_user[3], 32'd0);
            end
        end
        chk("prog_r0", dut.u_regfile.regs_user[0], 32'h41007700);
        chk("prog_r1", dut.u_regfile.regs_user[1], 32'd0);
        chk("prog_r2", dut.u_regfile.regs_user[2], 32'd1);
        chk("prog_r3", dut.u_regfile.regs_user[3], 32'd0);

        // c1 write mask, MOVS zero flag, failed condition
        mem[0] = 32'hE3E04000; mem[1] = 32'hEE014F10; mem[2] = 32'hEE115F10;
        mem[3] = 32'hE3B00000; mem[4] = 32'h13A01005;
        do_reset();
        for (int n = 0; n < 5; n++) run_instr(n % 2, 0, 1'b0);
        chk("c1_readback", dut.u_regfile.regs_user[5], 32'h00003384);
        chk("movs_z", 32'(dut.cpsr[30]), 32'd1);
        chk("movne_r1", dut.u_regfile.regs_user[1], 32'd0);

        // BL forward, then halt and debug freeze between instructions
        mem[0] = 32'hEB000002; mem[4] = 32'hE3A0700F; mem[5] = 32'hE3A08C01;
        do_reset();
        run_instr(0, 2, 1'b0);
        chk("bl_pc", dut.pc, 32'h10);
        chk("bl_lr", dut.u_regfile.regs_user[14], 32'h4);
        run_instr(0, 3, 1'b1);
        chk("mov_r7", dut.u_regfile.regs_user[7], 32'hF);

        // Reset during EXECUTE aborts the instruction
        chk("abort_fetch_addr", bus.mem_addr, 32'h14);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        m_reset();
        check_state();
        rst_n = 1'b0;
        #1;

        // Random instruction streams
        for (int i = 0; i < 256; i++) mem[i] = gen_instr();
        m_reset();
        do_reset();
        for (int n = 0; n < 300; n++)
            run_instr($urandom_range(0, 2),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0,
                      $urandom_range(0, 1) == 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
